// File: rtl/resp_misr.sv
// resp_misr -- 16-bit multiple-input signature register (MISR) that compacts
// a stream of 4-bit responses from a combinational stage under test.
//
// A start in IDLE seeds the signature, clears the sample counter and latches
// the number of samples to take. In CAPT each y_valid && y_ready cycle folds
// one y vector into the signature. After the last accepted sample the block
// spends exactly one cycle in DONE (done pulse), then returns to IDLE. The
// signature and count stay frozen until the next accepted start.
//
// Optional feature macro: RESP_MISR_CMP_EN
//   When defined, adds the golden input and the registered match output.
//   match is evaluated in the DONE cycle and held until the next start.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   capture request (only honoured in IDLE)
//   num_samples  in   CNT_W  samples to compress, latched on accepted start
//   y_valid      in   upstream response valid
//   y            in   4    response vector
//   golden       in   16   expected signature   (RESP_MISR_CMP_EN only)
//   y_ready      out  block accepts y this cycle (CAPT)
//   busy         out  high in CAPT and DONE
//   done         out  one-cycle pulse when the signature is final
//   signature    out  16   current MISR value
//   sample_cnt   out  CNT_W samples accepted since last start
//   match        out  signature == golden      (RESP_MISR_CMP_EN only)

module resp_misr #(
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             y_valid,
  input  logic [3:0]       y,
`ifdef RESP_MISR_CMP_EN
  input  logic [15:0]      golden,
`endif
  output logic             y_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] sample_cnt
`ifdef RESP_MISR_CMP_EN
  ,
  output logic             match
`endif
);

  // State encoding doubles as the output flags so y_ready/busy/done come
  // straight from flops: bit0 = y_ready, bit1 = busy, bit2 = done.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_CAPT = 3'b011,
    ST_DONE = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // One MISR step: shift left with feedback taps 15,14,12,3, then fold in y.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [3:0]  din);
    logic fb;
    fb = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
    return {sig[14:0], fb} ^ {12'h000, din};
  endfunction

  state_t           state_r,  state_s;
  logic [15:0]      sig_r,    sig_s;
  logic [CNT_W-1:0] cnt_r,    cnt_s;
  logic [CNT_W-1:0] tgt_r,    tgt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             xfer_s;
  logic             accept_s;

  assign xfer_s    = y_valid && (state_r == ST_CAPT);
  assign accept_s  = start && (state_r == ST_IDLE);
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state, signature and counter update.
  always_comb begin
    state_s = state_r;
    sig_s   = sig_r;
    cnt_s   = cnt_r;
    tgt_s   = tgt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          sig_s = SEED;
          cnt_s = CNT_ZERO;
          tgt_s = num_samples;
          if (num_samples == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPT: begin
        if (xfer_s) begin
          sig_s = misr_next(sig_r, y);
          cnt_s = cnt_inc_s;
          // The accepted transfer that reaches the target is the last one.
          if (cnt_inc_s == tgt_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPT;
          end
        end else begin
          state_s = ST_CAPT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, signature, counter and target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sig_r   <= SEED;
      cnt_r   <= CNT_ZERO;
      tgt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      sig_r   <= sig_s;
      cnt_r   <= cnt_s;
      tgt_r   <= tgt_s;
    end
  end

  assign y_ready    = state_r[0];
  assign busy       = state_r[1];
  assign done       = state_r[2];
  assign signature  = sig_r;
  assign sample_cnt = cnt_r;

`ifdef RESP_MISR_CMP_EN
  logic match_r;

  // Compare against golden once the signature is final; cleared on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
    end else if (accept_s) begin
      match_r <= 1'b0;
    end else if (state_r == ST_DONE) begin
      match_r <= (sig_r == golden);
    end else begin
      match_r <= match_r;
    end
  end

  assign match = match_r;
`endif

endmodule
